multdiv: RTL

MULTDIV -- requirements
Module: multdiv

---
 rtl/multdiv_if.sv | 20 ++
 rtl/multdiv.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/multdiv_if.sv
// rtl/multdiv_if.sv - operand/strobe/result bundle for the multdiv unit
interface multdiv_if;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY
  );
endinterface

// File: rtl/multdiv.sv
// rtl/multdiv.sv - iterative signed 32-bit multiplier (radix-2 Booth) and restoring divider
// One iteration per clock, 32 iterations per operation; any start strobe restarts the unit.
module multdiv (
  input  logic     clock,
  input  logic     reset,
  multdiv_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] mcand_q, mcand_d;   // multiplicand, or divisor magnitude
  logic [32:0] acc_q, acc_d;       // Booth high half, or partial remainder
  logic [31:0] mlier_q, mlier_d;   // multiplier low half, or dividend/quotient
  logic        qm1_q, qm1_d;
  logic        neg_q, neg_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;
  logic        rdy_q, rdy_d;

  logic [32:0] m_ext;
  logic [32:0] booth_sum;
  logic [63:0] prod;
  logic [32:0] rem_shift;
  logic [33:0] diff;
  logic [31:0] quo_mag;
  logic [31:0] quo_signed;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  always_comb begin
    m_ext = {mcand_q[31], mcand_q};
    case ({mlier_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + m_ext;
      2'b10:   booth_sum = acc_q - m_ext;
      default: booth_sum = acc_q;
    endcase
    // Product after this step's arithmetic shift; only meaningful on the last step.
    prod       = {booth_sum, mlier_q[31:1]};
    rem_shift  = {acc_q[31:0], mlier_q[31]};
    diff       = {1'b0, rem_shift} - {2'b00, mcand_q};
    quo_mag    = {mlier_q[30:0], ~diff[33]};
    quo_signed = neg_q ? -quo_mag : quo_mag;
    a_mag      = bus.data_operandA[31] ? -bus.data_operandA : bus.data_operandA;
    b_mag      = bus.data_operandB[31] ? -bus.data_operandB : bus.data_operandB;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mlier_d  = mlier_q;
    qm1_d    = qm1_q;
    neg_d    = neg_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;

    if (bus.ctrl_MULT) begin
      state_d  = MUL;
      cnt_d    = 6'd0;
      mcand_d  = bus.data_operandA;
      mlier_d  = bus.data_operandB;
      acc_d    = 33'd0;
      qm1_d    = 1'b0;
      neg_d    = 1'b0;
      result_d = 32'd0;
      exc_d    = 1'b0;
    end else if (bus.ctrl_DIV) begin
      state_d  = DIV;
      cnt_d    = 6'd0;
      mcand_d  = b_mag;
      mlier_d  = a_mag;
      acc_d    = 33'd0;
      qm1_d    = 1'b0;
      neg_d    = bus.data_operandA[31] ^ bus.data_operandB[31];
      result_d = 32'd0;
      exc_d    = 1'b0;
    end else begin
      case (state_q)
        MUL: begin
          acc_d   = {booth_sum[32], booth_sum[32:1]};
          mlier_d = {booth_sum[0], mlier_q[31:1]};
          qm1_d   = mlier_q[0];
          cnt_d   = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_d  = DONE;
            rdy_d    = 1'b1;
            result_d = prod[31:0];
            exc_d    = !((&prod[63:31]) || !(|prod[63:31]));
          end
        end
        DIV: begin
          if (mcand_q == 32'd0) begin
            state_d  = DONE;
            rdy_d    = 1'b1;
            result_d = 32'd0;
            exc_d    = 1'b1;
          end else begin
            acc_d   = diff[33] ? rem_shift : diff[32:0];
            mlier_d = quo_mag;
            cnt_d   = cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
              state_d  = DONE;
              rdy_d    = 1'b1;
              result_d = quo_signed;
              // Only -2^31 / -1 yields a positive quotient that does not fit.
              exc_d    = !neg_q && quo_mag[31];
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      mcand_q  <= 32'd0;
      acc_q    <= 33'd0;
      mlier_q  <= 32'd0;
      qm1_q    <= 1'b0;
      neg_q    <= 1'b0;
      result_q <= 32'd0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mlier_q  <= mlier_d;
      qm1_q    <= qm1_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;

endmodule
